// File: rtl/lvds_rx_pkg.sv
// Purpose : shared types and defaults for the LVDS rx idelay eye-training block.
// Latency : n/a (types, constants and one pure function).
// Backpr. : n/a.
package lvds_rx_pkg;

    localparam int TAP_W = 8;   // idelay code width
    localparam int WID_W = 9;   // eye width, 0..254

    localparam int TAP_MAX_DEF    = 253;
    localparam int SETTLE_CYC_DEF = 16;
    localparam int SAMPLE_CYC_DEF = 64;
    localparam int MIN_EYE_DEF    = 8;
    localparam int MON_WIN_DEF    = 1024;
    localparam int ERR_LIMIT_DEF  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_EVAL,
        ST_APPLY,
        ST_APPLY_SETTLE,
        ST_LOCKED,
        ST_FAIL
    } state_t;

    // Centre of a passing window, rounded down: start + floor((len-1)/2).
    // Only called with len >= 1, and the result never exceeds the last tap.
    function automatic logic [TAP_W-1:0] eye_center(input logic [TAP_W-1:0] start,
                                                    input logic [WID_W-1:0] len);
        logic [WID_W-1:0] half;
        logic [WID_W-1:0] sum;
        half = (len - 1'b1) >> 1;
        sum  = {1'b0, start} + half;
        return sum[TAP_W-1:0];
    endfunction

endpackage

// File: rtl/lvds_rx_eye_train_if.sv
// Purpose : lane-side bus between the training controller and one 7:1 deserializer lane.
// Latency : n/a (wires only).
// Backpr. : none; the lane streams a word every cycle.
// Signals : I_diff_pdata / I_diff_ndata - P and N leg parallel words from the lane
//           O_idelay_num                - idelay code driven back to the lane
// Modports: master = training controller, slave = lane deserializer.
interface lvds_rx_eye_train_if;
    logic [6:0]                    I_diff_pdata;
    logic [6:0]                    I_diff_ndata;
    logic [lvds_rx_pkg::TAP_W-1:0] O_idelay_num;

    modport master (input I_diff_pdata, input I_diff_ndata, output O_idelay_num);
    modport slave  (output I_diff_pdata, output I_diff_ndata, input O_idelay_num);
endinterface

// File: rtl/lvds_rx_eye_track.sv
// Purpose : run-length tracker; keeps the current and the longest passing tap run.
// Latency : best_* reflect an eval pulse on the following cycle.
// Backpr. : none; one eval per tap, sampled whenever eval is high.
// Ports   : clr clears all runs, eval/ok/tap present one tap verdict,
//           best_start/best_len give the earliest longest run seen.
module lvds_rx_eye_track
    import lvds_rx_pkg::*;
(
    input  logic             I_clk_1x,
    input  logic             I_rst_n,
    input  logic             clr,
    input  logic             eval,
    input  logic             ok,
    input  logic [TAP_W-1:0] tap,
    output logic [TAP_W-1:0] best_start,
    output logic [WID_W-1:0] best_len
);

    logic [TAP_W-1:0] cur_start;
    logic [WID_W-1:0] cur_len;
    logic [TAP_W-1:0] run_start;
    logic [WID_W-1:0] run_len;

    // The run including this tap: a fresh run starts at the current tap.
    always_comb begin
        run_start = (cur_len == '0) ? tap : cur_start;
        run_len   = cur_len + 1'b1;
    end

    always_ff @(posedge I_clk_1x or negedge I_rst_n) begin
        if (!I_rst_n) begin
            cur_start  <= '0;
            cur_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
        end else if (clr) begin
            cur_start  <= '0;
            cur_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
        end else if (eval) begin
            if (ok) begin
                cur_start <= run_start;
                cur_len   <= run_len;
                // Strictly longer only, so an equal later run never displaces
                // the earlier one.
                if (run_len > best_len) begin
                    best_start <= run_start;
                    best_len   <= run_len;
                end
            end else begin
                cur_len <= '0;
            end
        end
    end

endmodule

// File: rtl/lvds_rx_eye_train.sv
// Purpose : idelay eye training for one LVDS 7:1 lane: sweep, centre, then monitor lock.
// Latency : one full sweep costs (TAP_MAX+1)*(SETTLE_CYC+SAMPLE_CYC+1) cycles plus apply/settle.
// Backpr. : none; lane data is consumed every cycle, I_start is dropped while O_busy is high.
// Ports   : I_clk_1x/I_rst_n clock and async active-low reset; I_start starts a scan;
//           I_auto_retrain rescans on lock loss; lane = P/N words in, idelay code out;
//           O_busy/O_lock/O_fail status; O_eye_start/O_eye_width chosen window;
//           O_retrain_cnt saturating lock-loss count.
module lvds_rx_eye_train
    import lvds_rx_pkg::*;
#(
    parameter int TAP_MAX    = TAP_MAX_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int SAMPLE_CYC = SAMPLE_CYC_DEF,
    parameter int MIN_EYE    = MIN_EYE_DEF,
    parameter int MON_WIN    = MON_WIN_DEF,
    parameter int ERR_LIMIT  = ERR_LIMIT_DEF
) (
    input  logic                I_clk_1x,
    input  logic                I_rst_n,
    input  logic                I_start,
    input  logic                I_auto_retrain,
    lvds_rx_eye_train_if.master lane,
    output logic                O_busy,
    output logic                O_lock,
    output logic                O_fail,
    output logic [TAP_W-1:0]    O_eye_start,
    output logic [WID_W-1:0]    O_eye_width,
    output logic [7:0]          O_retrain_cnt
);

    localparam int CNT_MAX = (SETTLE_CYC > SAMPLE_CYC) ? SETTLE_CYC : SAMPLE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int WIN_W   = $clog2(MON_WIN + 1);
    // Holds ERR_LIMIT+2 so the saturated count plus this cycle's error never wraps.
    localparam int ERR_W   = $clog2(ERR_LIMIT + 3);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYC - 1);
    localparam logic [WIN_W-1:0] WIN_LAST    = WIN_W'(MON_WIN - 1);
    localparam logic [ERR_W-1:0] ERR_LIM     = ERR_W'(ERR_LIMIT);
    localparam logic [TAP_W-1:0] TAP_LAST    = TAP_W'(TAP_MAX);
    localparam logic [WID_W-1:0] MIN_LEN     = WID_W'(MIN_EYE);

    state_t           state;
    state_t           state_nxt;
    logic [6:0]       pdata_r;
    logic [6:0]       ndata_r;
    logic             match;
    logic [CNT_W-1:0] cnt;
    logic             tap_ok;
    logic [TAP_W-1:0] tap;
    logic [WIN_W-1:0] win_cnt;
    logic [ERR_W-1:0] err_cnt;
    logic [ERR_W-1:0] err_tot;
    logic [TAP_W-1:0] best_start;
    logic [WID_W-1:0] best_len;
    logic             start_req;
    logic             win_end;
    logic             lock_loss;
    logic             scan_go;
    logic             eye_ok;
    logic             trk_eval;

    // N leg is the inverted copy of P when the sample point sits in the eye.
    assign match = (pdata_r == ~ndata_r);

    always_comb begin
        start_req = I_start && (state == ST_IDLE || state == ST_LOCKED || state == ST_FAIL);
        win_end   = (state == ST_LOCKED) && (win_cnt == WIN_LAST);
        // Include the window's last cycle in the verdict.
        err_tot   = err_cnt + {{(ERR_W-1){1'b0}}, ~match};
        lock_loss = win_end && (err_tot > ERR_LIM);
        // A coincident start and lock loss collapse into a single rescan.
        scan_go   = start_req || (lock_loss && I_auto_retrain);
        eye_ok    = (best_len >= MIN_LEN);
    end

    lvds_rx_eye_track u_track (
        .I_clk_1x   (I_clk_1x),
        .I_rst_n    (I_rst_n),
        .clr        (scan_go),
        .eval       (trk_eval),
        .ok         (tap_ok),
        .tap        (tap),
        .best_start (best_start),
        .best_len   (best_len)
    );

    // FSM state register
    always_ff @(posedge I_clk_1x or negedge I_rst_n) begin
        if (!I_rst_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_FAIL: if (start_req) state_nxt = ST_SETTLE;
            ST_SETTLE:        if (cnt == SETTLE_LAST) state_nxt = ST_SAMPLE;
            ST_SAMPLE:        if (cnt == SAMPLE_LAST) state_nxt = ST_EVAL;
            ST_EVAL:          state_nxt = (tap < TAP_LAST) ? ST_SETTLE : ST_APPLY;
            ST_APPLY:         state_nxt = eye_ok ? ST_APPLY_SETTLE : ST_FAIL;
            ST_APPLY_SETTLE:  if (cnt == SETTLE_LAST) state_nxt = ST_LOCKED;
            ST_LOCKED: begin
                if (scan_go)        state_nxt = ST_SETTLE;
                else if (lock_loss) state_nxt = ST_IDLE;
            end
            default:          state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: status flags are pure state decodes
    always_comb begin
        O_busy   = 1'b0;
        O_lock   = 1'b0;
        O_fail   = 1'b0;
        trk_eval = 1'b0;
        case (state)
            ST_SETTLE, ST_SAMPLE, ST_APPLY, ST_APPLY_SETTLE: O_busy = 1'b1;
            ST_EVAL: begin
                O_busy   = 1'b1;
                trk_eval = 1'b1;
            end
            ST_LOCKED: O_lock = 1'b1;
            ST_FAIL:   O_fail = 1'b1;
            default: ;
        endcase
    end

    // Datapath
    always_ff @(posedge I_clk_1x or negedge I_rst_n) begin
        if (!I_rst_n) begin
            pdata_r       <= '0;
            ndata_r       <= '0;
            cnt           <= '0;
            tap_ok        <= 1'b0;
            tap           <= '0;
            win_cnt       <= '0;
            err_cnt       <= '0;
            O_eye_start   <= '0;
            O_eye_width   <= '0;
            O_retrain_cnt <= '0;
        end else begin
            pdata_r <= lane.I_diff_pdata;
            ndata_r <= lane.I_diff_ndata;

            // Phase counter restarts on every state change.
            if (state_nxt != state)
                cnt <= '0;
            else if (state inside {ST_SETTLE, ST_SAMPLE, ST_APPLY_SETTLE})
                cnt <= cnt + 1'b1;

            if (state == ST_SETTLE)
                tap_ok <= 1'b1;
            else if (state == ST_SAMPLE && !match)
                tap_ok <= 1'b0;

            if (scan_go)
                tap <= '0;
            else if (state == ST_EVAL && tap < TAP_LAST)
                tap <= tap + 1'b1;
            else if (state == ST_APPLY)
                tap <= eye_ok ? eye_center(best_start, best_len) : '0;

            if (state == ST_APPLY) begin
                O_eye_start <= best_start;
                O_eye_width <= best_len;
            end

            // Monitor counters run only inside LOCKED and restart each window.
            if (state == ST_LOCKED && !win_end) begin
                win_cnt <= win_cnt + 1'b1;
                if (err_cnt <= ERR_LIM)
                    err_cnt <= err_tot;
            end else begin
                win_cnt <= '0;
                err_cnt <= '0;
            end

            if (lock_loss && O_retrain_cnt != 8'hFF)
                O_retrain_cnt <= O_retrain_cnt + 1'b1;
        end
    end

    assign lane.O_idelay_num = tap;

endmodule

// File: tb/tb_lvds_rx_eye_train.sv
module tb_lvds_rx_eye_train;

    localparam int TAP_MAX    = 253;
    localparam int SETTLE_CYC = 4;
    localparam int SAMPLE_CYC = 8;
    localparam int MIN_EYE    = 8;
    localparam int MON_WIN    = 1024;
    localparam int ERR_LIMIT  = 4;
    localparam int TAP_COST   = SETTLE_CYC + SAMPLE_CYC + 1;

    logic       I_clk_1x;
    logic       I_rst_n;
    logic       I_start;
    logic       I_auto_retrain;
    logic       O_busy;
    logic       O_lock;
    logic       O_fail;
    logic [7:0] O_eye_start;
    logic [8:0] O_eye_width;
    logic [7:0] O_retrain_cnt;

    lvds_rx_eye_train_if lane_if ();

    lvds_rx_eye_train #(
        .TAP_MAX    (TAP_MAX),
        .SETTLE_CYC (SETTLE_CYC),
        .SAMPLE_CYC (SAMPLE_CYC),
        .MIN_EYE    (MIN_EYE),
        .MON_WIN    (MON_WIN),
        .ERR_LIMIT  (ERR_LIMIT)
    ) dut (
        .I_clk_1x       (I_clk_1x),
        .I_rst_n        (I_rst_n),
        .I_start        (I_start),
        .I_auto_retrain (I_auto_retrain),
        .lane           (lane_if),
        .O_busy         (O_busy),
        .O_lock         (O_lock),
        .O_fail         (O_fail),
        .O_eye_start    (O_eye_start),
        .O_eye_width    (O_eye_width),
        .O_retrain_cnt  (O_retrain_cnt)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int ticks    = 0;
    logic [255:0] pass_mask;
    logic inject;

    initial I_clk_1x = 1'b0;
    always #5 I_clk_1x = ~I_clk_1x;

    // Lane model: taps in pass_mask deliver N = ~P, anything else (or an
    // injected error) delivers an N word that differs from ~P in one bit.
    always @(posedge I_clk_1x) begin : lane_model
        logic [6:0] pw;
        logic       good;
        #2;
        pw   = 7'($urandom);
        good = pass_mask[lane_if.O_idelay_num] && !inject;
        lane_if.I_diff_pdata = pw;
        lane_if.I_diff_ndata = good ? ~pw : (~pw ^ (7'd1 << $urandom_range(6, 0)));
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge I_clk_1x);
            ticks++;
        end
    endtask

    task automatic inject_bad(input int n);
        inject = 1'b1;
        tick(n);
        inject = 1'b0;
    endtask

    task automatic set_window(input int lo, input int hi);
        for (int t = lo; t <= hi; t++) pass_mask[t] = 1'b1;
    endtask

    // Reference: earliest longest run of consecutive passing taps in 0..TAP_MAX.
    task automatic model(output int es, output int ew, output int et, output int ef);
        es = 0;
        ew = 0;
        for (int s = 0; s <= TAP_MAX; s++) begin
            int len = 0;
            while (s + len <= TAP_MAX && pass_mask[s + len]) len++;
            if (len > ew) begin
                ew = len;
                es = s;
            end
        end
        if (ew >= MIN_EYE) begin
            et = es + (ew - 1) / 2;
            ef = 0;
        end else begin
            et = 0;
            ef = 1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, O_busy, 0);
        check({tag, " lock"}, O_lock, 0);
        check({tag, " fail"}, O_fail, 0);
        check({tag, " idelay"}, lane_if.O_idelay_num, 0);
        check({tag, " eye_start"}, O_eye_start, 0);
        check({tag, " eye_width"}, O_eye_width, 0);
        check({tag, " retrain"}, O_retrain_cnt, 0);
    endtask

    // Runs one scan (optionally issuing the start pulse) until O_busy falls and
    // checks duration, result and visited tap range against the model.
    task automatic run_and_check(input string tag, input bit do_start, input bit pulses);
        int es, ew, et, ef, exp_cyc, cyc, max_tap;
        model(es, ew, et, ef);
        exp_cyc = (TAP_MAX + 1) * TAP_COST + 1 + (ef != 0 ? 0 : SETTLE_CYC);
        if (do_start) begin
            I_start = 1'b1;
            @(negedge I_clk_1x);
            I_start = 1'b0;
        end
        cyc = 0;
        max_tap = 0;
        while (O_busy === 1'b1 && cyc < exp_cyc + 100) begin
            if (int'(lane_if.O_idelay_num) > max_tap) max_tap = int'(lane_if.O_idelay_num);
            I_start = pulses && (cyc % 701 == 3);
            @(negedge I_clk_1x);
            cyc++;
        end
        I_start = 1'b0;
        check({tag, " cycles"}, cyc, exp_cyc);
        check({tag, " max_tap"}, max_tap, TAP_MAX);
        check({tag, " eye_start"}, O_eye_start, es);
        check({tag, " eye_width"}, O_eye_width, ew);
        check({tag, " idelay"}, lane_if.O_idelay_num, et);
        check({tag, " lock"}, O_lock, (ef == 0));
        check({tag, " fail"}, O_fail, (ef != 0));
        check({tag, " busy"}, O_busy, 0);
    endtask

    initial begin
        int lo, hi, cyc;
        I_rst_n        = 1'b0;
        I_start        = 1'b0;
        I_auto_retrain = 1'b0;
        inject         = 1'b0;
        pass_mask      = '0;
        repeat (3) @(negedge I_clk_1x);
        check_all_zero("reset");
        I_rst_n = 1'b1;
        repeat (2) @(negedge I_clk_1x);
        check_all_zero("idle");

        // Eye 40..79, with stray start pulses that must not disturb the scan.
        set_window(40, 79);
        run_and_check("w40_79", 1'b1, 1'b1);
        check("w40_79 literal tap", lane_if.O_idelay_num, 59);

        // 5 bad cycles in one window with auto retrain: lock drops at window end.
        I_auto_retrain = 1'b1;
        ticks = 0;
        tick(100);
        inject_bad(5);
        while (O_lock === 1'b1 && ticks < 3 * MON_WIN) tick(1);
        check("loss5 lock_cycles", ticks, MON_WIN);
        check("loss5 retrain_cnt", O_retrain_cnt, 1);
        check("loss5 busy", O_busy, 1);
        check("loss5 idelay", lane_if.O_idelay_num, 0);
        run_and_check("relock", 1'b0, 1'b0);
        check("relock literal tap", lane_if.O_idelay_num, 59);

        // 4 bad cycles is within tolerance: lock held for two full windows.
        ticks = 0;
        tick(100);
        inject_bad(4);
        while (O_lock === 1'b1 && ticks < 2 * MON_WIN) tick(1);
        check("hold4 lock_cycles", ticks, 2 * MON_WIN);
        check("hold4 retrain_cnt", O_retrain_cnt, 1);

        // Lock loss without auto retrain parks in idle with the tap held.
        I_auto_retrain = 1'b0;
        tick(100);
        inject_bad(5);
        while (O_lock === 1'b1 && ticks < 4 * MON_WIN) tick(1);
        check("loss_noauto lock_cycles", ticks, 3 * MON_WIN);
        tick(3);
        check("loss_noauto retrain_cnt", O_retrain_cnt, 2);
        check("loss_noauto busy", O_busy, 0);
        check("loss_noauto fail", O_fail, 0);
        check("loss_noauto idelay", lane_if.O_idelay_num, 59);

        // Two windows, longer one wins.
        pass_mask = '0;
        set_window(10, 19);
        set_window(100, 129);
        run_and_check("w10_100", 1'b1, 1'b0);
        check("w10_100 literal tap", lane_if.O_idelay_num, 114);

        // Equal windows: earlier one wins.
        pass_mask = '0;
        set_window(10, 29);
        set_window(100, 119);
        run_and_check("tie", 1'b1, 1'b0);
        check("tie literal tap", lane_if.O_idelay_num, 19);

        // Too narrow an eye.
        pass_mask = '0;
        set_window(50, 54);
        run_and_check("narrow", 1'b1, 1'b0);
        check("narrow literal width", O_eye_width, 5);

        // Window touching the last tap (restart from FAIL).
        pass_mask = '0;
        set_window(230, 253);
        run_and_check("top", 1'b1, 1'b0);
        check("top literal tap", lane_if.O_idelay_num, 241);

        // Random lane eyes.
        for (int r = 0; r < 2; r++) begin
            pass_mask = '0;
            repeat ($urandom_range(3, 1)) begin
                lo = $urandom_range(TAP_MAX, 0);
                hi = lo + $urandom_range(40, 0);
                if (hi > TAP_MAX) hi = TAP_MAX;
                set_window(lo, hi);
            end
            run_and_check($sformatf("rand%0d", r), 1'b1, 1'b0);
        end

        // Reset asserted during SAMPLE at tap 120.
        pass_mask = '0;
        set_window(40, 79);
        I_start = 1'b1;
        @(negedge I_clk_1x);
        I_start = 1'b0;
        cyc = 0;
        while (lane_if.O_idelay_num !== 8'd120 && cyc < 200 * TAP_COST) begin
            @(negedge I_clk_1x);
            cyc++;
        end
        check("rst_mid reached tap", lane_if.O_idelay_num, 120);
        repeat (SETTLE_CYC + 2) @(negedge I_clk_1x);
        check("rst_mid busy before", O_busy, 1);
        #2;
        I_rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(negedge I_clk_1x);
        I_rst_n = 1'b1;
        repeat (2) @(negedge I_clk_1x);
        check("rst_mid idle busy", O_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
